// File: rtl/mtime_timer_bank.sv
// mtime_timer_bank: free-running machine timer with a programmable prescaler
// and NCH independent compare channels (one-shot or periodic). Each channel
// has a sticky pending bit, and the block drives a combined interrupt line.
//
// Ports:
//   clock, reset       rising-edge clock, asynchronous active-low reset
//   count_en           global count enable (prescaler and mtime hold when low)
//   prescale           mtime advances once every prescale+1 enabled cycles
//   wr_en/wr_sel/      one-cycle register write: wr_field 0 = compare,
//   wr_field/wr_data   1 = period; wr_sel selects the channel
//   mode               per channel: 0 = one-shot, 1 = periodic
//   mtie               per-channel interrupt enable
//   ack                per-channel pending clear pulse
//   mtime              current timer value
//   pend               sticky pending status (independent of mtie)
//   mtip               pend & mtie (combinational)
//   irq                OR of mtip
module mtime_timer_bank #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned NCH        = 4,
  parameter int unsigned PRESCALE_W = 8,
  localparam int unsigned SEL_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  count_en,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  wr_en,
  input  logic [SEL_W-1:0]      wr_sel,
  input  logic                  wr_field,
  input  logic [XLEN-1:0]       wr_data,
  input  logic [NCH-1:0]        mode,
  input  logic [NCH-1:0]        mtie,
  input  logic [NCH-1:0]        ack,
  output logic [XLEN-1:0]       mtime,
  output logic [NCH-1:0]        pend,
  output logic [NCH-1:0]        mtip,
  output logic                  irq
);

  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
  logic [XLEN-1:0]       mtime_q, mtime_d;
  logic [XLEN-1:0]       cmp_q    [NCH];
  logic [XLEN-1:0]       cmp_d    [NCH];
  logic [XLEN-1:0]       period_q [NCH];
  logic [XLEN-1:0]       period_d [NCH];
  logic [NCH-1:0]        armed_q, armed_d;
  logic [NCH-1:0]        pend_q, pend_d;
  logic [NCH-1:0]        fire_c;
  logic                  tick_c;

  // Prescaler and mtime counter. A prescale lowered below pcnt simply lets
  // pcnt run on and wrap before it matches again.
  always_comb begin
    pcnt_d  = pcnt_q;
    mtime_d = mtime_q;
    tick_c  = count_en && (pcnt_q == prescale);
    if (tick_c) begin
      pcnt_d  = '0;
      mtime_d = mtime_q + XLEN'(1);
    end else if (count_en) begin
      pcnt_d = pcnt_q + PRESCALE_W'(1);
    end
  end

  // Per-channel compare/period/armed/pending update.
  // Priority: compare write > fire > ack. A fire either reloads cmp (periodic
  // with nonzero period) or disarms, so each mtime value fires at most once
  // even while mtime is held by the prescaler or count_en.
  always_comb begin
    cmp_d    = cmp_q;
    period_d = period_q;
    armed_d  = armed_q;
    pend_d   = pend_q;
    fire_c   = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      fire_c[i] = armed_q[i] && (mtime_q == cmp_q[i]);
      if (wr_en && wr_field && (wr_sel == SEL_W'(i))) begin
        period_d[i] = wr_data;
      end
      if (wr_en && !wr_field && (wr_sel == SEL_W'(i))) begin
        cmp_d[i]   = wr_data;
        armed_d[i] = 1'b1;
        pend_d[i]  = 1'b0;
      end else if (fire_c[i]) begin
        pend_d[i] = 1'b1;
        if (mode[i] && (period_q[i] != '0)) begin
          cmp_d[i] = cmp_q[i] + period_q[i];
        end else begin
          armed_d[i] = 1'b0;
        end
      end else if (ack[i]) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  // State registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pcnt_q  <= '0;
      mtime_q <= '0;
      armed_q <= '0;
      pend_q  <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        cmp_q[i]    <= '0;
        period_q[i] <= '0;
      end
    end else begin
      pcnt_q   <= pcnt_d;
      mtime_q  <= mtime_d;
      armed_q  <= armed_d;
      pend_q   <= pend_d;
      cmp_q    <= cmp_d;
      period_q <= period_d;
    end
  end

  assign mtime = mtime_q;
  assign pend  = pend_q;
  assign mtip  = pend_q & mtie;
  assign irq   = |(pend_q & mtie);

endmodule

// File: tb/tb_mtime_timer_bank.sv
// tb_mtime_timer_bank: directed checks of mtime_timer_bank. A 32-bit, 4-channel
// instance covers counting, one-shot/periodic fires, collisions, mtie gating,
// count freeze and async reset; a small 8-bit instance makes mtime wrap
// reachable for the periodic-reload-wrap and one-shot no-refire cases.
module tb_mtime_timer_bank;

  logic        clock = 1'b0;
  logic        reset = 1'b0;

  logic        count_en = 1'b1;
  logic [7:0]  prescale = '0;
  logic        wr_en    = 1'b0;
  logic [1:0]  wr_sel   = '0;
  logic        wr_field = 1'b0;
  logic [31:0] wr_data  = '0;
  logic [3:0]  mode     = '0;
  logic [3:0]  mtie     = '0;
  logic [3:0]  ack      = '0;
  logic [31:0] mtime;
  logic [3:0]  pend;
  logic [3:0]  mtip;
  logic        irq;

  logic        s_count_en = 1'b0;
  logic [3:0]  s_prescale = '0;
  logic        s_wr_en    = 1'b0;
  logic        s_wr_sel   = 1'b0;
  logic        s_wr_field = 1'b0;
  logic [7:0]  s_wr_data  = '0;
  logic [1:0]  s_mode     = '0;
  logic [1:0]  s_mtie     = '0;
  logic [1:0]  s_ack      = '0;
  logic [7:0]  s_mtime;
  logic [1:0]  s_pend;
  logic [1:0]  s_mtip;
  logic        s_irq;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  mtime_timer_bank u_dut (
    .clock    (clock),
    .reset    (reset),
    .count_en (count_en),
    .prescale (prescale),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_field (wr_field),
    .wr_data  (wr_data),
    .mode     (mode),
    .mtie     (mtie),
    .ack      (ack),
    .mtime    (mtime),
    .pend     (pend),
    .mtip     (mtip),
    .irq      (irq)
  );

  mtime_timer_bank #(.XLEN(8), .NCH(2), .PRESCALE_W(4)) u_small (
    .clock    (clock),
    .reset    (reset),
    .count_en (s_count_en),
    .prescale (s_prescale),
    .wr_en    (s_wr_en),
    .wr_sel   (s_wr_sel),
    .wr_field (s_wr_field),
    .wr_data  (s_wr_data),
    .mode     (s_mode),
    .mtie     (s_mtie),
    .ack      (s_ack),
    .mtime    (s_mtime),
    .pend     (s_pend),
    .mtip     (s_mtip),
    .irq      (s_irq)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    wr_en = 1'b0;
    ack   = '0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic wr_main(input logic [1:0] sel, input logic field, input logic [31:0] data);
    wr_en    = 1'b1;
    wr_sel   = sel;
    wr_field = field;
    wr_data  = data;
    @(negedge clock);
    wr_en = 1'b0;
  endtask

  task automatic ack_main(input logic [3:0] a);
    ack = a;
    @(negedge clock);
    ack = '0;
  endtask

  task automatic wr_small(input logic sel, input logic field, input logic [7:0] data);
    s_wr_en    = 1'b1;
    s_wr_sel   = sel;
    s_wr_field = field;
    s_wr_data  = data;
    @(negedge clock);
    s_wr_en = 1'b0;
  endtask

  task automatic ack_small(input logic [1:0] a);
    s_ack = a;
    @(negedge clock);
    s_ack = '0;
  endtask

  // Returns at the first negedge where mtime equals val, or after budget cycles.
  task automatic wait_mtime(input logic [31:0] val, input int budget);
    int n = 0;
    while (mtime !== val && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("wait_mtime", 64'(mtime), 64'(val));
  endtask

  task automatic wait_smtime(input logic [7:0] val, input int budget);
    int n = 0;
    while (s_mtime !== val && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("wait_s_mtime", 64'(s_mtime), 64'(val));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;

    // Reset and free-run count with prescale=0.
    repeat (3) @(negedge clock);
    check("rst_mtime", 64'(mtime), 64'd0);
    check("rst_pend",  64'(pend),  64'd0);
    check("rst_irq",   64'(irq),   64'd0);
    reset = 1'b1;
    @(negedge clock);
    check("cnt_1", 64'(mtime), 64'd1);
    @(negedge clock);
    check("cnt_2", 64'(mtime), 64'd2);
    @(negedge clock);
    check("cnt_3", 64'(mtime), 64'd3);
    check("cnt_pend", 64'(pend), 64'd0);
    check("cnt_irq",  64'(irq),  64'd0);

    // One-shot ch0 at 0xF0.
    do_reset();
    mtie = 4'b0001;
    mode = 4'b0000;
    wr_main(2'd0, 1'b0, 32'h0000_00F0);
    wait_mtime(32'hF0, 400);
    check("os_pre_pend", 64'(pend[0]), 64'd0);
    check("os_pre_irq",  64'(irq),     64'd0);
    @(negedge clock);
    check("os_pend", 64'(pend[0]), 64'd1);
    check("os_mtip", 64'(mtip[0]), 64'd1);
    check("os_irq",  64'(irq),     64'd1);
    repeat (3) @(negedge clock);
    check("os_sticky", 64'(pend[0]), 64'd1);
    ack_main(4'b0001);
    check("os_ack_pend", 64'(pend[0]), 64'd0);
    check("os_ack_irq",  64'(irq),     64'd0);
    repeat (4) @(negedge clock);
    check("os_norefire", 64'(pend[0]), 64'd0);

    // Periodic ch1 under prescale=3: one fire per mtime value.
    prescale = 8'd3;
    do_reset();
    mtie = 4'b0010;
    mode = 4'b0010;
    wr_main(2'd1, 1'b1, 32'h10);
    wr_main(2'd1, 1'b0, 32'h20);
    for (int k = 0; k < 3; k++) begin
      v = 32'h20 + 32'(k) * 32'h10;
      wait_mtime(v, 200);
      check("per_pre",  64'(pend[1]), 64'd0);
      @(negedge clock);
      check("per_fire", 64'(pend[1]), 64'd1);
      check("per_irq",  64'(irq),     64'd1);
      ack_main(4'b0010);
      check("per_ack",  64'(pend[1]), 64'd0);
      repeat (2) @(negedge clock);
      check("per_next_val", 64'(mtime),   64'(v + 32'd1));
      check("per_once",     64'(pend[1]), 64'd0);
    end

    // Ch2 collisions: fire+ack, then fire+cmp write.
    prescale = 8'd0;
    do_reset();
    mtie = 4'b0100;
    mode = 4'b0000;
    wr_main(2'd2, 1'b0, 32'h10);
    wait_mtime(32'h10, 100);
    ack_main(4'b0100);
    check("col_fire_ack", 64'(pend[2]), 64'd1);
    ack_main(4'b0100);
    check("col_ack_clr", 64'(pend[2]), 64'd0);
    mode = 4'b0100;
    wr_main(2'd2, 1'b1, 32'h4);
    wr_main(2'd2, 1'b0, 32'h20);
    wait_mtime(32'h20, 100);
    wr_main(2'd2, 1'b0, 32'h30);
    check("col_fire_wr", 64'(pend[2]), 64'd0);
    wait_mtime(32'h26, 100);
    check("col_no_reload", 64'(pend[2]), 64'd0);
    wait_mtime(32'h30, 100);
    check("col_new_pre", 64'(pend[2]), 64'd0);
    @(negedge clock);
    check("col_new_fire", 64'(pend[2]), 64'd1);

    // Ch3 with mtie off, then mtie on; count freeze; async reset.
    do_reset();
    mtie = 4'b0000;
    mode = 4'b0000;
    wr_main(2'd3, 1'b0, 32'h5);
    wait_mtime(32'h5, 50);
    check("mtie_pre", 64'(pend[3]), 64'd0);
    @(negedge clock);
    check("mtie_mtime", 64'(mtime),   64'd6);
    check("mtie_pend",  64'(pend[3]), 64'd1);
    check("mtie_mtip",  64'(mtip[3]), 64'd0);
    check("mtie_irq",   64'(irq),     64'd0);
    mtie = 4'b1000;
    #1;
    check("mtie_on_mtip", 64'(mtip[3]), 64'd1);
    check("mtie_on_irq",  64'(irq),     64'd1);
    wait_mtime(32'h0A, 50);
    count_en = 1'b0;
    wr_main(2'd0, 1'b0, 32'h0A);
    check("frz_mtime", 64'(mtime),   64'h0A);
    check("frz_pre",   64'(pend[0]), 64'd0);
    @(negedge clock);
    check("frz_fire", 64'(pend[0]), 64'd1);
    ack_main(4'b0001);
    check("frz_ack", 64'(pend[0]), 64'd0);
    repeat (3) @(negedge clock);
    check("frz_once",   64'(pend[0]), 64'd0);
    check("frz_mtime2", 64'(mtime),   64'h0A);
    #2;
    reset = 1'b0;
    #1;
    check("arst_mtime", 64'(mtime), 64'd0);
    check("arst_pend",  64'(pend),  64'd0);
    check("arst_mtip",  64'(mtip),  64'd0);
    check("arst_irq",   64'(irq),   64'd0);

    // Small 8-bit instance: periodic reload wraps, one-shot does not refire.
    count_en   = 1'b1;
    s_count_en = 1'b1;
    s_prescale = 4'd0;
    s_mode     = 2'b01;
    s_mtie     = 2'b11;
    @(negedge clock);
    reset = 1'b1;
    wr_small(1'b0, 1'b1, 8'h10);
    wr_small(1'b0, 1'b0, 8'hF8);
    wr_small(1'b1, 1'b0, 8'hF0);
    wait_smtime(8'hF0, 400);
    check("s_os_pre", 64'(s_pend[1]), 64'd0);
    @(negedge clock);
    check("s_os_fire", 64'(s_pend[1]), 64'd1);
    ack_small(2'b10);
    wait_smtime(8'hF8, 50);
    check("s_per_pre", 64'(s_pend[0]), 64'd0);
    @(negedge clock);
    check("s_per_fire", 64'(s_pend[0]), 64'd1);
    check("s_per_irq",  64'(s_irq),     64'd1);
    ack_small(2'b01);
    wait_smtime(8'h08, 50);
    check("s_wrap_pre", 64'(s_pend[0]), 64'd0);
    @(negedge clock);
    check("s_wrap_fire", 64'(s_pend[0]), 64'd1);
    wait_smtime(8'hF2, 400);
    check("s_os_norefire", 64'(s_pend[1]), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mtime_timer_bank.md
Name: mtime_timer_bank

Overview:
- Multi-channel machine-timer block; generalises the single-compare mtime interrupter to NCH independent compare channels.
- Adds a programmable prescaler, per-channel one-shot/periodic modes, sticky pending bits with acknowledge, and a combined interrupt line.
- Sits beside the CSR unit. It owns the free-running mtime counter and drives machine timer interrupt requests to the trap controller.

Parameters:
- XLEN, 32: width of mtime, compare and period registers.
- NCH, 4: number of compare channels, 1..16.
- PRESCALE_W, 8: width of the prescaler divide value.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- count_en  in  1  global count enable; when low, prescaler and mtime hold.
- prescale  in  PRESCALE_W  divide value; mtime advances once every prescale+1 enabled cycles.
- wr_en  in  1  register write strobe, one cycle.
- wr_sel  in  $clog2(NCH) (min 1)  target channel index.
- wr_field  in  1  0 = compare register, 1 = period register.
- wr_data  in  XLEN  write data.
- mode  in  NCH  per channel: 0 = one-shot, 1 = periodic.
- mtie  in  NCH  per-channel interrupt enable.
- ack  in  NCH  per-channel pending clear, one-cycle pulse.
- mtime  out  XLEN  current timer value.
- pend  out  NCH  sticky pending status, independent of mtie.
- mtip  out  NCH  pend & mtie.
- irq  out  1  OR of mtip.

Behaviour:
- Reset (reset=0, async): mtime=0, prescaler count=0, all cmp=0, all period=0, armed=0, pend=0. Consequently mtip=0 and irq=0. Reset asserted mid-count or mid-write discards all state immediately.
- Prescaler:
  - pcnt counts only when count_en=1.
  - tick is asserted in the cycle where count_en=1 and pcnt==prescale. That same edge sets pcnt to 0 and increments mtime.
  - Otherwise pcnt increments.
  - prescale=0: mtime increments every enabled cycle.
  - prescale changed below the current pcnt: pcnt continues counting, wraps at 2^PRESCALE_W, then matches normally. No special handling.
- mtime: unsigned XLEN counter; wraps 2^XLEN-1 -> 0 with no flag.
- Writes (wr_en=1):
  - wr_field=0: cmp[wr_sel] <= wr_data, armed[wr_sel] <= 1, pend[wr_sel] <= 0.
  - wr_field=1: period[wr_sel] <= wr_data. Armed state and pend are unchanged.
  - wr_sel >= NCH is ignored.
- Match: channel i fires when armed[i]=1 and mtime==cmp[i], evaluated on registered mtime each cycle.
  - Fire sets pend[i]=1 on the next edge, so latency is 1 cycle from mtime==cmp to pend/mtip/irq high.
  - Comparison is equality only, not >=. A cmp value written below the current mtime fires after mtime wraps.
- On fire, by mode[i] sampled at the fire cycle:
  - One-shot (mode[i]=0), or periodic with period[i]=0: armed[i] <= 0.
  - Periodic with period[i]!=0: cmp[i] <= cmp[i]+period[i] mod 2^XLEN, armed stays 1. Wrap of the sum is legal.
  - Either way, a channel fires exactly once per mtime value even when mtime holds for several cycles under the prescaler.
- Simultaneous events on one channel, same cycle:
  - Fire and ack: pend stays 1 (set wins).
  - Fire and cmp write: the write wins. New cmp, armed=1, pend=0, no reload.
  - Ack with pend=0: no effect.
- Writing cmp equal to the current mtime: compared in the next cycle, so it fires if mtime has not yet advanced.
- count_en=0: no ticks. Matches are still evaluated against the frozen mtime, so a cmp write equal to the frozen mtime fires once.
- mtie affects only mtip/irq; pend latches regardless, so enabling mtie later raises mtip immediately (combinational).

Test Plan:
- Reset low 3 cycles then release, prescale=0, count_en=1 -> mtime=0 during reset, then 1,2,3... on successive edges; pend=0, irq=0.
- Ch0 one-shot, mtie[0]=1, write cmp=0xF0 -> pend[0]/mtip[0]/irq rise 1 cycle after mtime==0xF0 and stay high. Ack[0] clears them; no refire after mtime wraps past 0xF0 again.
- Ch1 periodic, period=0x10, cmp=0x20, prescale=3 -> pend[1] fires at mtime 0x20, 0x30, 0x40. Acks between fires clear pend. Exactly one fire per value even though each mtime value lasts 4 cycles.
- Ch2: fire and ack[2] in the same cycle -> pend[2]=1. Then cmp write coinciding with a fire -> pend[2]=0, armed, new cmp used.
- mtie[3]=0, ch3 cmp=5 -> pend[3]=1 at mtime 6, mtip[3]=0, irq=0. Then mtie[3]=1 -> mtip[3] and irq go high the same cycle.
- Periodic ch0 with cmp=0xFFFFFFF8, period=0x10 -> after the fire, cmp=0x8. Fires again after mtime wraps to 0x8. Reset asserted mid-run -> all outputs 0 asynchronously, before the next edge.
